gap_window_scheduler: RTL and testbench

- Sequences a windowed run of the programmable "1, N zeros, 1" gap detector on serial input J.
- Accepts a start command with gap length and window length, arms the detector, and samples J for exactly win_len cycles.
- Counts pattern hits with overlap and reports busy, done, a per-hit pulse, a saturating hit count and an overflow flag.
- Sits between the system control FSM and the serial line, replacing hard-wired fixed-gap detection.

---
 rtl/gap_window_scheduler_if.sv | 27 ++
 rtl/gap_window_scheduler.sv | 117 +++++++++++
 tb/tb_gap_window_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gap_window_scheduler_if.sv
// Control/data bundle between the system control FSM, the serial line and the gap window scheduler.
// master drives the run request, configuration and J; slave reports status and hit results.
interface gap_window_scheduler_if #(
  parameter int CNT_W = 3,
  parameter int WIN_W = 8,
  parameter int HIT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] gap_len;
  logic [WIN_W-1:0] win_len;
  logic             J;
  logic             busy;
  logic             done;
  logic             hit_pulse;
  logic [HIT_W-1:0] hit_count;
  logic             overflow;

  modport master (
    output start, gap_len, win_len, J,
    input  busy, done, hit_pulse, hit_count, overflow
  );

  modport slave (
    input  start, gap_len, win_len, J,
    output busy, done, hit_pulse, hit_count, overflow
  );
endinterface

// File: rtl/gap_window_scheduler.sv
// Runs the "1, N zeros, 1" gap detector over a window of exactly win_len J samples.
// Hits overlap, the hit count saturates with a sticky overflow, and every output is registered.
module gap_window_scheduler #(
  parameter int CNT_W = 3,
  parameter int WIN_W = 8,
  parameter int HIT_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  gap_window_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT1, SEEN1, COUNT} state_t;

  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  state_t           r_state;
  state_t           w_det_next;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_zc;
  logic [CNT_W-1:0] w_zc_next;
  logic [WIN_W-1:0] r_win;
  logic             r_busy;
  logic             r_done;
  logic             r_hit_pulse;
  logic [HIT_W-1:0] r_hit_count;
  logic             r_overflow;
  logic             w_hit;

  // Detector next state for the sample on J; only applied while a window is running.
  always_comb begin
    w_det_next = r_state;
    w_zc_next  = r_zc;
    w_hit      = 1'b0;
    case (r_state)
      WAIT1: begin
        if (bus.J) w_det_next = SEEN1;
      end
      SEEN1: begin
        if (bus.J) begin
          w_hit = (r_gap == '0);
        end else if (r_gap == '0) begin
          w_det_next = WAIT1;
        end else begin
          w_det_next = COUNT;
          w_zc_next  = CNT_W'(1);
        end
      end
      COUNT: begin
        if (bus.J) begin
          // Closing 1 doubles as the opening 1 of the next candidate.
          w_hit      = (r_zc == r_gap);
          w_det_next = SEEN1;
        end else if (r_zc == r_gap) begin
          w_det_next = WAIT1;
        end else begin
          w_zc_next = r_zc + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gap       <= '0;
      r_zc        <= '0;
      r_win       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit_pulse <= 1'b0;
      r_hit_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_hit_pulse <= 1'b0;
      if (!r_busy) begin
        if (bus.start) begin
          r_gap       <= bus.gap_len;
          r_win       <= bus.win_len;
          r_zc        <= '0;
          r_hit_count <= '0;
          r_overflow  <= 1'b0;
          if (bus.win_len != '0) begin
            r_busy  <= 1'b1;
            r_state <= WAIT1;
          end else begin
            r_done  <= 1'b1;
          end
        end
      end else begin
        r_win   <= r_win - 1'b1;
        r_state <= w_det_next;
        r_zc    <= w_zc_next;
        if (w_hit) begin
          r_hit_pulse <= 1'b1;
          if (r_hit_count == HIT_MAX) r_overflow  <= 1'b1;
          else                        r_hit_count <= r_hit_count + 1'b1;
        end
        // Last sample of the window: any partial pattern is dropped here.
        if (r_win == WIN_W'(1)) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hit_pulse = r_hit_pulse;
  assign bus.hit_count = r_hit_count;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_gap_window_scheduler.sv
// Bench for gap_window_scheduler: directed windows plus random windows, with a queue of expected
// hit/done events built from a pattern-search reference model and consumed by an output monitor.
module tb_gap_window_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gap_window_scheduler_if #(.CNT_W(3), .WIN_W(8), .HIT_W(4)) bus ();

  gap_window_scheduler #(.CNT_W(3), .WIN_W(8), .HIT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       hit;
    logic       done;
    logic [3:0] cnt;
    logic       ovf;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  logic smp[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Any hit_pulse or done must match the oldest outstanding expected event.
  always @(negedge clk) begin
    if (!rst && (bus.hit_pulse || bus.done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: hit_pulse=%0b done=%0b, expected none (t=%0t)",
                 bus.hit_pulse, bus.done, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hit_pulse", int'(bus.hit_pulse), int'(mon_e.hit));
        chk("done",      int'(bus.done),      int'(mon_e.done));
        chk("hit_count", int'(bus.hit_count), int'(mon_e.cnt));
        chk("overflow",  int'(bus.overflow),  int'(mon_e.ovf));
      end
    end
  end

  // Reference: sample k is a hit when it is 1, the sample gap+1 earlier is 1 and inside the
  // window, and every sample strictly between them is 0.
  task automatic expect_window(input int gap, input int win);
    int cnt = 0;
    bit ovf = 1'b0;
    bit hit;
    bit allz;
    for (int k = 0; k < win; k++) begin
      hit = 1'b0;
      if (smp[k] === 1'b1 && k >= gap + 1 && smp[k-gap-1] === 1'b1) begin
        allz = 1'b1;
        for (int j = k - gap; j < k; j++) if (smp[j] === 1'b1) allz = 1'b0;
        hit = allz;
      end
      if (hit) begin
        if (cnt == 15) ovf = 1'b1;
        else           cnt++;
      end
      if (hit || k == win - 1) exp_q.push_back(ev_t'{hit, (k == win - 1), 4'(cnt), ovf});
    end
    if (win == 0) exp_q.push_back(ev_t'{1'b0, 1'b1, 4'd0, 1'b0});
  endtask

  task automatic push_n(input logic v, input int n);
    for (int i = 0; i < n; i++) smp.push_back(v);
  endtask

  // Called 1 time unit after a posedge with the DUT idle; returns 1 unit into the done cycle.
  task automatic run_win(input int gap, input int win, input int ign_at);
    expect_window(gap, win);
    bus.start   = 1'b1;
    bus.gap_len = 3'(gap);
    bus.win_len = 8'(win);
    bus.J       = 1'($urandom);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.gap_len = 3'($urandom);
    bus.win_len = 8'($urandom);
    chk("busy_after_accept", int'(bus.busy), int'(win != 0));
    for (int k = 0; k < win; k++) begin
      bus.J = smp[k];
      if (k == ign_at) begin
        bus.start   = 1'b1;
        bus.gap_len = 3'd5;
        bus.win_len = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("busy_at_done", int'(bus.busy), 0);
  endtask

  initial begin
    int gap, win, idle, ign;
    bus.start   = 1'b0;
    bus.gap_len = '0;
    bus.win_len = '0;
    bus.J       = 1'b0;
    #12;
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_done",      int'(bus.done),      0);
    chk("rst_hit_pulse", int'(bus.hit_pulse), 0);
    chk("rst_hit_count", int'(bus.hit_count), 0);
    chk("rst_overflow",  int'(bus.overflow),  0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Exact gap twice, then a trailing partial pattern.
    smp.delete(); push_n(1, 1); push_n(0, 6); push_n(1, 1); push_n(0, 6); push_n(1, 1); push_n(0, 5);
    run_win(6, 20, -1);
    // Back-to-back: too many zeros, then too few.
    smp.delete(); push_n(1, 1); push_n(0, 7); push_n(1, 1); push_n(0, 5); push_n(1, 2);
    run_win(6, 16, -1);
    // gap 0 on all ones: saturation and overflow, last hit coincides with done.
    smp.delete(); push_n(1, 20);
    run_win(0, 20, -1);
    // start during the window is ignored.
    smp.delete(); push_n(0, 5); push_n(1, 1); push_n(0, 2); push_n(1, 1); push_n(0, 1);
    run_win(2, 10, 3);
    // Zero-length window.
    smp.delete();
    run_win(0, 0, -1);
    @(posedge clk); #1;
    chk("win0_idle_busy", int'(bus.busy), 0);

    // Reset mid-window after one hit: everything clears and no done follows.
    bus.gap_len = 3'd0;
    bus.win_len = 8'd20;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_q.push_back(ev_t'{1'b1, 1'b0, 4'd1, 1'b0});
    bus.J = 1'b1; @(posedge clk); #1;
    bus.J = 1'b1; @(posedge clk); #1;
    bus.J = 1'b0; @(posedge clk); #1;
    bus.J = 1'b0; @(posedge clk); #1;
    chk("pre_rst_count", int'(bus.hit_count), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",      int'(bus.busy),      0);
    chk("arst_done",      int'(bus.done),      0);
    chk("arst_hit_pulse", int'(bus.hit_pulse), 0);
    chk("arst_hit_count", int'(bus.hit_count), 0);
    chk("arst_overflow",  int'(bus.overflow),  0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", int'(bus.busy), 0);
    smp.delete(); push_n(1, 1); push_n(0, 1); push_n(1, 1);
    run_win(1, 3, -1);

    // Random windows, random idle gaps (including back-to-back) and stray start pulses.
    for (int n = 0; n < 30; n++) begin
      gap  = $urandom_range(0, 7);
      win  = $urandom_range(0, 40);
      idle = $urandom_range(0, 2);
      ign  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      smp.delete();
      for (int k = 0; k < win; k++) smp.push_back(($urandom_range(0, gap + 1) == 0) ? 1'b1 : 1'b0);
      repeat (idle) begin @(posedge clk); #1; end
      run_win(gap, win, ign);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
